lieat_exu_muldiv_arb: RTL and testbench

Round-robin arbiter that shares one multiply/divide unit between two issue requesters (issue lane 0 and issue lane 1). It muxes the winning request onto the unit's input handshake and records the owner of each accepted operation in an in-order owner FIFO. It then steers each unit result back to the lane that issued it. It sits in the EXU between the two issue lanes and the muldiv unit, and adds zero cycles of latency on either path.

---
 rtl/lieat_exu_muldiv_arb.sv | 130 +++++++++++++
 tb/tb_lieat_exu_muldiv_arb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lieat_exu_muldiv_arb.sv
// Round-robin share of one muldiv unit between two issue lanes; an in-order
// owner FIFO steers each unit result back to the lane that issued it.
module lieat_exu_muldiv_arb #(
  parameter int XLEN       = 32,
  parameter int RGIDX_SIZE = 5,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [XLEN-1:0]       req0_pc,
  input  logic [XLEN-1:0]       req0_src1,
  input  logic [XLEN-1:0]       req0_src2,
  input  logic [XLEN-1:0]       req0_infobus,
  input  logic [RGIDX_SIZE-1:0] req0_rd,
  input  logic                  req0_rdwen,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [XLEN-1:0]       req1_pc,
  input  logic [XLEN-1:0]       req1_src1,
  input  logic [XLEN-1:0]       req1_src2,
  input  logic [XLEN-1:0]       req1_infobus,
  input  logic [RGIDX_SIZE-1:0] req1_rd,
  input  logic                  req1_rdwen,

  output logic                  mdu_i_valid,
  input  logic                  mdu_i_ready,
  output logic [XLEN-1:0]       mdu_i_pc,
  output logic [XLEN-1:0]       mdu_i_src1,
  output logic [XLEN-1:0]       mdu_i_src2,
  output logic [XLEN-1:0]       mdu_i_infobus,
  output logic [RGIDX_SIZE-1:0] mdu_i_rd,
  output logic                  mdu_i_rdwen,

  input  logic                  mdu_o_valid,
  output logic                  mdu_o_ready,
  input  logic [XLEN-1:0]       mdu_o_pc,
  input  logic [XLEN-1:0]       mdu_o_data,
  input  logic [RGIDX_SIZE-1:0] mdu_o_rd,
  input  logic                  mdu_o_wen,

  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [XLEN-1:0]       rsp0_pc,
  output logic [XLEN-1:0]       rsp0_data,
  output logic [RGIDX_SIZE-1:0] rsp0_rd,
  output logic                  rsp0_wen,

  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [XLEN-1:0]       rsp1_pc,
  output logic [XLEN-1:0]       rsp1_data,
  output logic [RGIDX_SIZE-1:0] rsp1_rd,
  output logic                  rsp1_wen,

  output logic                  busy,
  output logic                  err_orphan
);

  localparam int AW = $clog2(DEPTH);

  logic             rr_ptr;
  logic [DEPTH-1:0] owner;
  logic [AW:0]      wptr, rptr;
  logic             fifo_full, fifo_empty;
  logic             grant0, grant1, can_issue, push, pop, head, head_ready;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign busy       = ~fifo_empty;

  // rr_ptr only matters on a tie; a lone requester always wins
  assign grant1 = req1_valid & (~req0_valid | rr_ptr);
  assign grant0 = req0_valid & (~req1_valid | ~rr_ptr);

  // full blocks issue even when a pop lands in the same cycle
  assign can_issue   = mdu_i_ready & ~fifo_full;
  assign mdu_i_valid = (req0_valid | req1_valid) & ~fifo_full;
  assign req0_ready  = grant0 & can_issue;
  assign req1_ready  = grant1 & can_issue;
  assign push        = mdu_i_valid & mdu_i_ready;

  assign mdu_i_pc      = grant1 ? req1_pc      : req0_pc;
  assign mdu_i_src1    = grant1 ? req1_src1    : req0_src1;
  assign mdu_i_src2    = grant1 ? req1_src2    : req0_src2;
  assign mdu_i_infobus = grant1 ? req1_infobus : req0_infobus;
  assign mdu_i_rd      = grant1 ? req1_rd      : req0_rd;
  assign mdu_i_rdwen   = grant1 ? req1_rdwen   : req0_rdwen;

  // result return: head of the owner FIFO selects the destination lane
  assign head        = owner[rptr[AW-1:0]];
  assign head_ready  = head ? rsp1_ready : rsp0_ready;
  assign mdu_o_ready = head_ready & ~fifo_empty;
  assign rsp0_valid  = mdu_o_valid & ~fifo_empty & ~head;
  assign rsp1_valid  = mdu_o_valid & ~fifo_empty & head;
  assign pop         = mdu_o_valid & mdu_o_ready;

  assign rsp0_pc   = mdu_o_pc;
  assign rsp0_data = mdu_o_data;
  assign rsp0_rd   = mdu_o_rd;
  assign rsp0_wen  = mdu_o_wen;
  assign rsp1_pc   = mdu_o_pc;
  assign rsp1_data = mdu_o_data;
  assign rsp1_rd   = mdu_o_rd;
  assign rsp1_wen  = mdu_o_wen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= 1'b0;
      owner      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) begin
        owner[wptr[AW-1:0]] <= grant1;
        wptr                <= wptr + 1'b1;
        rr_ptr              <= ~grant1;
      end
      if (pop)
        rptr <= rptr + 1'b1;
      if (mdu_o_valid & fifo_empty)
        err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lieat_exu_muldiv_arb.sv
// Directed checks of arbitration, owner-FIFO routing, full/backpressure,
// orphan detection and mid-flight reset for lieat_exu_muldiv_arb.
module tb_lieat_exu_muldiv_arb;
  localparam int XLEN = 32, RG = 5, DEPTH = 2;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic req0_valid, req0_ready, req0_rdwen, req1_valid, req1_ready, req1_rdwen;
  logic [XLEN-1:0] req0_pc, req0_src1, req0_src2, req0_infobus;
  logic [XLEN-1:0] req1_pc, req1_src1, req1_src2, req1_infobus;
  logic [RG-1:0] req0_rd, req1_rd, mdu_i_rd, mdu_o_rd, rsp0_rd, rsp1_rd;
  logic mdu_i_valid, mdu_i_ready, mdu_i_rdwen, mdu_o_valid, mdu_o_ready, mdu_o_wen;
  logic [XLEN-1:0] mdu_i_pc, mdu_i_src1, mdu_i_src2, mdu_i_infobus;
  logic [XLEN-1:0] mdu_o_pc, mdu_o_data, rsp0_pc, rsp0_data, rsp1_pc, rsp1_data;
  logic rsp0_valid, rsp0_ready, rsp0_wen, rsp1_valid, rsp1_ready, rsp1_wen;
  logic busy, err_orphan;

  int errs = 0, checks = 0;

  lieat_exu_muldiv_arb #(.XLEN(XLEN), .RGIDX_SIZE(RG), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pc(req0_pc),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_infobus(req0_infobus),
    .req0_rd(req0_rd), .req0_rdwen(req0_rdwen),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pc(req1_pc),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_infobus(req1_infobus),
    .req1_rd(req1_rd), .req1_rdwen(req1_rdwen),
    .mdu_i_valid(mdu_i_valid), .mdu_i_ready(mdu_i_ready), .mdu_i_pc(mdu_i_pc),
    .mdu_i_src1(mdu_i_src1), .mdu_i_src2(mdu_i_src2), .mdu_i_infobus(mdu_i_infobus),
    .mdu_i_rd(mdu_i_rd), .mdu_i_rdwen(mdu_i_rdwen),
    .mdu_o_valid(mdu_o_valid), .mdu_o_ready(mdu_o_ready), .mdu_o_pc(mdu_o_pc),
    .mdu_o_data(mdu_o_data), .mdu_o_rd(mdu_o_rd), .mdu_o_wen(mdu_o_wen),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_pc(rsp0_pc),
    .rsp0_data(rsp0_data), .rsp0_rd(rsp0_rd), .rsp0_wen(rsp0_wen),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_pc(rsp1_pc),
    .rsp1_data(rsp1_data), .rsp1_rd(rsp1_rd), .rsp1_wen(rsp1_wen),
    .busy(busy), .err_orphan(err_orphan)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1-2ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0; mdu_i_ready = 1; mdu_o_valid = 0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  initial begin
    idle();
    req0_pc = 32'h100; req0_src1 = 32'h2; req0_src2 = 32'h3; req0_infobus = 32'h11;
    req0_rd = 5'd3; req0_rdwen = 1;
    req1_pc = 32'h200; req1_src1 = 32'hB; req1_src2 = 32'hC; req1_infobus = 32'h22;
    req1_rd = 5'd7; req1_rdwen = 0;
    mdu_o_pc = 32'h100; mdu_o_data = 32'h6; mdu_o_rd = 5'd3; mdu_o_wen = 1;

    // reset state
    tick(); #1;
    chk("rst_busy", busy, 0);
    chk("rst_orphan", err_orphan, 0);
    chk("rst_ivalid", mdu_i_valid, 0);
    chk("rst_r0rdy", req0_ready, 0);
    chk("rst_rsp0v", rsp0_valid, 0);
    rst = 0;
    tick();

    // single lane 0, result two cycles later
    req0_valid = 1; #1;
    chk("s_r0rdy", req0_ready, 1);
    chk("s_r1rdy", req1_ready, 0);
    chk("s_ivalid", mdu_i_valid, 1);
    chk("s_isrc1", mdu_i_src1, 32'h2);
    chk("s_ird", mdu_i_rd, 5'd3);
    tick();
    req0_valid = 0; #1;
    chk("s_busy", busy, 1);
    tick();
    mdu_o_valid = 1; #1;
    chk("s_rsp0v", rsp0_valid, 1);
    chk("s_rsp0d", rsp0_data, 32'h6);
    chk("s_rsp1v", rsp1_valid, 0);
    chk("s_oready", mdu_o_ready, 1);
    tick();
    mdu_o_valid = 0; #1;
    chk("s_busy_end", busy, 0);

    // tie round-robin with results one cycle behind issue
    do_reset();
    req0_src1 = 32'hA;
    for (int k = 0; k < 5; k++) begin
      req0_valid = (k < 4); req1_valid = (k < 4);
      mdu_o_valid = (k > 0);
      #1;
      if (k < 4) begin
        chk($sformatf("rr_r0rdy%0d", k), req0_ready, (k % 2 == 0));
        chk($sformatf("rr_r1rdy%0d", k), req1_ready, (k % 2 == 1));
        chk($sformatf("rr_src%0d", k), mdu_i_src1, (k % 2 == 0) ? 32'hA : 32'hB);
      end
      if (k > 0) begin
        chk($sformatf("rr_rsp0v%0d", k), rsp0_valid, ((k - 1) % 2 == 0));
        chk($sformatf("rr_rsp1v%0d", k), rsp1_valid, ((k - 1) % 2 == 1));
      end
      tick();
    end
    idle(); #1;
    chk("rr_busy_end", busy, 0);

    // FIFO full: two issues, then blocked until a pop, no same-cycle bypass
    do_reset();
    req0_valid = 1; req1_valid = 1; #1;
    chk("f_iss0", req0_ready, 1);
    tick(); #1;
    chk("f_iss1", req1_ready, 1);
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("f_iv%0d", k), mdu_i_valid, 0);
      chk($sformatf("f_r0rdy%0d", k), req0_ready, 0);
      chk($sformatf("f_r1rdy%0d", k), req1_ready, 0);
      tick();
    end
    mdu_o_valid = 1; #1;
    chk("f_pop_rsp0v", rsp0_valid, 1);
    chk("f_pop_iv", mdu_i_valid, 0);
    tick();
    mdu_o_valid = 0; #1;
    chk("f_resume_iv", mdu_i_valid, 1);
    chk("f_resume_r0", req0_ready, 1);

    // response backpressure on a lane-1 head
    do_reset();
    req1_valid = 1;
    tick();
    req1_valid = 0; mdu_o_valid = 1; rsp1_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_oready%0d", k), mdu_o_ready, 0);
      chk($sformatf("bp_rsp1v%0d", k), rsp1_valid, 1);
      chk($sformatf("bp_rsp0v%0d", k), rsp0_valid, 0);
      chk($sformatf("bp_busy%0d", k), busy, 1);
      tick();
    end
    rsp1_ready = 1; #1;
    chk("bp_oready_go", mdu_o_ready, 1);
    tick();
    mdu_o_valid = 0; #1;
    chk("bp_busy_end", busy, 0);

    // orphan result on an empty FIFO
    do_reset();
    mdu_o_valid = 1; #1;
    chk("o_rsp0v", rsp0_valid, 0);
    chk("o_rsp1v", rsp1_valid, 0);
    chk("o_oready", mdu_o_ready, 0);
    chk("o_err_pre", err_orphan, 0);
    tick();
    mdu_o_valid = 0; #1;
    chk("o_err_set", err_orphan, 1);
    tick(); tick(); #1;
    chk("o_err_sticky", err_orphan, 1);

    // reset mid-flight: rr_ptr left at 1 with two entries queued
    do_reset();
    req0_valid = 1;
    tick(); tick();
    req0_valid = 0; #1;
    chk("m_busy_pre", busy, 1);
    chk("m_full", mdu_i_valid, 0);
    rst = 1; #1;
    chk("m_busy_async", busy, 0);
    req0_valid = 1; req1_valid = 1; #1;
    chk("m_tie_in_rst", req0_ready, 1);
    tick();
    rst = 0; #1;
    chk("m_tie_r0", req0_ready, 1);
    chk("m_tie_r1", req1_ready, 0);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
